alu16_seq_driver: RTL
=====================

// Module: alu16_seq_driver
// PURPOSE
//  Multi-cycle MUL/DIVU engine that drives an external 16-bit ALU through its in_a/in_b/op port
//  and consumes its r/isZero result. Sits between decode and a shared alu16 instance.
//  Supports 16x16 multiply (low half) and unsigned divide by iterating ADD/SLT/SUB on that ALU.
//  Upstream sees a start/busy/done handshake.
// PARAMETERS
//  WIDTH   16    datapath width; iteration count = WIDTH (only 16 supported)
//  OP_OR   3'd1  ALU op code: OR
//  OP_ADD  3'd2  ALU op code: ADD
//  OP_SLT  3'd4  ALU op code: unsigned set-less-than
//  OP_SUB  3'd6  ALU op code: SUB
// PORTS
//  clk        in   1   clock, single domain
//  reset      in   1   synchronous, active-high reset
//  start      in   1   command request; sampled only in IDLE
//  cmd        in   1   0 = MUL, 1 = DIVU
//  opnd_a     in   16  multiplicand / dividend
//  opnd_b     in   16  multiplier / divisor
//  busy       out  1   high in every state except IDLE
//  done       out  1   one-cycle pulse; result/result_hi/err valid
//  result     out  16  MUL: low product; DIVU: quotient
//  result_hi  out  16  MUL: 0; DIVU: remainder
//  err        out  1   DIVU by zero, or DIVU with divide compiled out
//  alu_a      out  16  to ALU in_a
//  alu_b      out  16  to ALU in_b
//  alu_op     out  3   to ALU op
//  alu_r      in   16  from ALU r (combinational, same cycle)
//  alu_zero   in   1   from ALU isZero
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset is synchronous and active-high.
//  - Reset: state = IDLE; busy, done and err = 0; result and result_hi = 0. Internal regs are cleared.
//  - Reset mid-operation aborts the operation. No done is issued.
//  - Idle ALU drive: alu_op = 3'd0 (AND), alu_a = alu_b = 0.
//  - States and transitions:
//    - IDLE: if start = 1, latch operands and clear acc/quot/rem and count.
//      MUL goes to MUL_STEP; DIVU goes to CHECK.
//    - MUL_STEP: alu_op = ADD, alu_a = acc, alu_b = mplier[0] ? mcand : 0.
//      Then acc <= alu_r, mcand <<= 1, mplier >>= 1, count++.
//      Leaves after 16 cycles to DONE. Sum wraps mod 2^16.
//    - CHECK: alu_op = OR, alu_a = divisor, alu_b = 0.
//      If alu_zero: err = 1, result = 16'hFFFF, result_hi = dividend, go to DONE.
//      Otherwise go to DIV_CMP.
//    - DIV_CMP: rs = {rem[14:0], quot[15]}; quot <<= 1; alu_op = SLT, alu_a = rs, alu_b = divisor.
//      If alu_r[0] = 1: rem <= rs, quot bit0 = 0, next bit.
//      Else go to DIV_SUB with rem <= rs.
//    - DIV_SUB: alu_op = SUB, alu_a = rem, alu_b = divisor. rem <= alu_r, quot bit0 = 1, next bit.
//    - After the 16th bit go to DONE. rs never exceeds 16 bits, because rem < 2^k after k bits.
//    - DONE: done = 1 for one cycle; result regs are loaded; then go to IDLE.
//  - Latency, counting the accepting edge as 0:
//    - MUL: done is high 17 cycles later.
//    - DIVU: 18 + popcount(quotient) cycles.
//    - DIVU by zero: 2 cycles.
//  - start is ignored while busy, including the DONE cycle. Next accept is possible in the cycle after DONE.
//  - result, result_hi and err hold until the next accepted start. err clears on that accept.
//  - cmd and opnd_* are don't-care except at the accepting edge.
// CONFIGURATION
//  ALU_SEQ_DIV_EN defined: DIVU path is present as above.
//  ALU_SEQ_DIV_EN undefined: no CHECK/DIV_CMP/DIV_SUB states.
//    A DIVU start goes directly to DONE with err = 1, result = 0, result_hi = 0 (done 1 cycle later).
//    MUL is unchanged.
// TESTING
//  1 MUL 0x0003*0x0005 -> done at +17, result=0x000F, result_hi=0, err=0
//  2 MUL 0x1234*0x0100 -> result=0x3400 (truncated), alu_op=2 on every busy cycle
//  3 DIVU 100/7 -> result=0x000E, result_hi=0x0002, err=0, done at +21
//  4 DIVU 0x1234/0 -> done at +2, err=1, result=0xFFFF, result_hi=0x1234; undefined macro: err=1, result=0 at +1
//  5 DIVU 0xFFFF/0x8001 -> result=0x0001, result_hi=0x7FFE; start pulses while busy ignored
//  6 reset high during 5th MUL_STEP -> next cycle busy=0, result=0, no done; new MUL then completes normally

Source files
------------

// File: rtl/alu16_seq_driver.sv
// alu16_seq_driver: multi-cycle MUL/DIVU sequencer driving a shared 16-bit ALU; define ALU_SEQ_DIV_EN to include the divider
module alu16_seq_driver #(
    parameter int         WIDTH  = 16,
    parameter logic [2:0] OP_OR  = 3'd1,
    parameter logic [2:0] OP_ADD = 3'd2,
    parameter logic [2:0] OP_SLT = 3'd4,
    parameter logic [2:0] OP_SUB = 3'd6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmd,
    input  logic [WIDTH-1:0] opnd_a,
    input  logic [WIDTH-1:0] opnd_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zero
);
`ifdef ALU_SEQ_DIV_EN
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_CHECK, S_DIV_CMP, S_DIV_SUB, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif
    state_t           r_state;
    logic             r_cmd;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [3:0]       r_cnt;
    logic             w_last;
    assign w_last = r_cnt == 4'(WIDTH - 1);
`ifdef ALU_SEQ_DIV_EN
    logic             r_dz;
    logic [WIDTH-1:0] w_rs;
    assign w_rs = {r_acc[WIDTH-2:0], r_a[WIDTH-1]};
`else
    logic w_unused;
    assign w_unused = ^{alu_zero, OP_OR, OP_SLT, OP_SUB};
`endif
    // ALU drive; a multiply keeps ADD on the bus through DONE, where the drained multiplier adds zero
    always_comb begin
        alu_op = 3'd0;
        alu_a  = '0;
        alu_b  = '0;
        if (r_state != S_IDLE && !r_cmd) begin
            alu_op = OP_ADD;
            alu_a  = r_acc;
            alu_b  = r_b[0] ? r_a : '0;
        end
`ifdef ALU_SEQ_DIV_EN
        else if (r_state == S_CHECK) begin
            alu_op = OP_OR;
            alu_a  = r_b;
        end else if (r_state == S_DIV_CMP) begin
            alu_op = OP_SLT;
            alu_a  = w_rs;
            alu_b  = r_b;
        end else if (r_state == S_DIV_SUB) begin
            alu_op = OP_SUB;
            alu_a  = r_acc;
            alu_b  = r_b;
        end
`endif
    end
    // Sequencer: MUL uses r_a/r_b as shifting multiplicand/multiplier, DIVU uses r_a as quotient and r_acc as remainder
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cmd     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            result_hi <= '0;
`ifdef ALU_SEQ_DIV_EN
            r_dz      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_cmd <= cmd;
                    r_a   <= opnd_a;
                    r_b   <= opnd_b;
                    r_acc <= '0;
                    r_cnt <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
                    r_dz    <= 1'b0;
                    r_state <= cmd ? S_CHECK : S_MUL;
`else
                    r_state <= cmd ? S_DONE : S_MUL;
`endif
                end
                S_MUL: begin
                    r_acc <= alu_r;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) r_state <= S_DONE;
                end
`ifdef ALU_SEQ_DIV_EN
                S_CHECK: begin
                    r_dz    <= alu_zero;
                    r_state <= alu_zero ? S_DONE : S_DIV_CMP;
                end
                S_DIV_CMP: begin
                    r_acc <= w_rs;
                    r_a   <= {r_a[WIDTH-2:0], 1'b0};
                    if (alu_r[0]) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_last) r_state <= S_DONE;
                    end else begin
                        r_state <= S_DIV_SUB;
                    end
                end
                S_DIV_SUB: begin
                    r_acc   <= alu_r;
                    r_a[0]  <= 1'b1;
                    r_cnt   <= r_cnt + 4'd1;
                    r_state <= w_last ? S_DONE : S_DIV_CMP;
                end
`endif
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
`ifdef ALU_SEQ_DIV_EN
                    err       <= r_cmd & r_dz;
                    result    <= r_cmd ? (r_dz ? '1 : r_a) : r_acc;
                    result_hi <= r_cmd ? (r_dz ? r_a : r_acc) : '0;
`else
                    err       <= r_cmd;
                    result    <= r_cmd ? '0 : r_acc;
                    result_hi <= '0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
